pwm_multi: RTL and testbench

//   Multi-channel PWM generator: CHANNELS outputs share one prescaled period counter.

---
 rtl/pwm_multi.sv | 176 +++++++++++++++++
 tb/tb_pwm_multi.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
//============================================================================
// Module      : pwm_multi
// Description : Multi-channel PWM generator. All channels share one
//               prescaled period counter. Duty and mode are double-buffered
//               (shadow -> active at the period boundary) so updates never
//               produce runt pulses. Edge-aligned or center-aligned counting.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module pwm_multi #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [PRESCALE_W-1:0]     prescale,
    input  logic                      mode_in,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    input  logic                      duty_load,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_start,
    output logic [WIDTH-1:0]          cnt
);

    // Counter limits and mode encoding
    localparam logic [WIDTH-1:0] c_CNT_MAX     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_CNT_ZERO    = {WIDTH{1'b0}};
    localparam logic             c_MODE_EDGE   = 1'b0;
    localparam logic             c_MODE_CENTER = 1'b1;

    // Count-direction state machine encoding
    localparam logic [0:0] c_ST_UP   = 1'b0;
    localparam logic [0:0] c_ST_DOWN = 1'b1;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [PRESCALE_W-1:0]     r_pre_cnt;
    logic [WIDTH-1:0]          r_cnt;
    logic [0:0]                r_dir;
    logic [CHANNELS*WIDTH-1:0] r_shadow_duty;
    logic                      r_shadow_mode;
    logic [CHANNELS*WIDTH-1:0] r_active_duty;
    logic                      r_active_mode;
    logic [CHANNELS-1:0]       r_pwm;
    logic                      r_period_start;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                      w_tick;
    logic [PRESCALE_W-1:0]     w_pre_next;
    logic                      w_count_down;
    logic [WIDTH-1:0]          w_cnt_step;
    logic                      w_boundary;
    logic [0:0]                w_dir_next;
    logic                      w_take_shadow;
    logic [CHANNELS*WIDTH-1:0] w_shadow_duty_next;
    logic                      w_shadow_mode_next;
    logic [CHANNELS-1:0]       w_cmp;

    // Prescaler: a tick whenever the divider matches the programmed value.
    // A live decrease of prescale below pre_cnt lets pre_cnt roll over its
    // full range before matching again.
    assign w_tick     = en & (r_pre_cnt == prescale);
    assign w_pre_next = w_tick ? {PRESCALE_W{1'b0}} : r_pre_cnt + 1'b1;

    // Next counter value if a tick happens; a boundary is a tick landing on 0
    assign w_cnt_step = w_count_down ? (r_cnt - 1'b1) : (r_cnt + 1'b1);
    assign w_boundary = w_tick & (w_cnt_step == c_CNT_ZERO);

    // Shadow contents as they will be after this cycle; the active copy
    // samples this so a load coinciding with a boundary is used at once.
    assign w_shadow_duty_next = duty_load ? duty_in : r_shadow_duty;
    assign w_shadow_mode_next = duty_load ? mode_in : r_shadow_mode;
    assign w_take_shadow      = ~en | w_boundary;

    // Direction state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir <= c_ST_UP;
        end else begin
            r_dir <= w_dir_next;
        end
    end

    // Direction next-state: turn around at MAX in center mode; every
    // boundary (and disable) restarts counting upward
    always_comb begin
        w_dir_next = r_dir;
        if (!en) begin
            w_dir_next = c_ST_UP;
        end else if (w_tick) begin
            if (w_boundary) begin
                w_dir_next = c_ST_UP;
            end else if ((r_active_mode == c_MODE_CENTER) &&
                         (r_dir == c_ST_UP) && (w_cnt_step == c_CNT_MAX)) begin
                w_dir_next = c_ST_DOWN;
            end
        end
    end

    // Direction output decode: only center mode ever counts down
    always_comb begin
        w_count_down = 1'b0;
        if ((r_active_mode == c_MODE_CENTER) && (r_dir == c_ST_DOWN)) begin
            w_count_down = 1'b1;
        end
    end

    // Prescaler and period counter; both parked at zero while disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt <= {PRESCALE_W{1'b0}};
            r_cnt     <= c_CNT_ZERO;
        end else if (!en) begin
            r_pre_cnt <= {PRESCALE_W{1'b0}};
            r_cnt     <= c_CNT_ZERO;
        end else begin
            r_pre_cnt <= w_pre_next;
            if (w_tick) begin
                r_cnt <= w_cnt_step;
            end
        end
    end

    // Shadow registers capture the host's duty/mode on each load strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_duty <= {(CHANNELS*WIDTH){1'b0}};
            r_shadow_mode <= c_MODE_EDGE;
        end else begin
            r_shadow_duty <= w_shadow_duty_next;
            r_shadow_mode <= w_shadow_mode_next;
        end
    end

    // Active registers follow the shadow only at a boundary or while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active_duty <= {(CHANNELS*WIDTH){1'b0}};
            r_active_mode <= c_MODE_EDGE;
        end else if (w_take_shadow) begin
            r_active_duty <= w_shadow_duty_next;
            r_active_mode <= w_shadow_mode_next;
        end
    end

    // Per-channel duty compare against the current counter value
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            assign w_cmp[gi] = (r_active_duty[gi*WIDTH +: WIDTH] > r_cnt);
        end
    endgenerate

    // Registered outputs: PWM levels and the period-start pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm          <= {CHANNELS{1'b0}};
            r_period_start <= 1'b0;
        end else begin
            r_pwm          <= en ? w_cmp : {CHANNELS{1'b0}};
            r_period_start <= w_boundary;
        end
    end

    assign pwm_out      = r_pwm;
    assign period_start = r_period_start;
    assign cnt          = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pwm_multi.sv
//============================================================================
// Module      : tb_pwm_multi
// Description : Directed self-checking bench for pwm_multi (WIDTH=8,
//               CHANNELS=4). Inputs change on the falling edge, outputs are
//               sampled on the falling edge.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_pwm_multi;

    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  prescale;
    logic        mode_in;
    logic [31:0] duty_in;
    logic        duty_load;
    logic [3:0]  pwm_out;
    logic        period_start;
    logic [7:0]  cnt;

    int n_assert;
    int n_fail;

    // Results of the most recent measurement window
    int         hi [4];
    int         ps_n;
    int         first_ps;
    logic [7:0] c254, c255, c256;
    int         found;
    int         run_hi0;
    logic [7:0] c0;

    pwm_multi #(
        .WIDTH      (8),
        .CHANNELS   (4),
        .PRESCALE_W (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .prescale     (prescale),
        .mode_in      (mode_in),
        .duty_in      (duty_in),
        .duty_load    (duty_load),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .cnt          (cnt)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit
    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Step until cnt equals val, at most limit cycles
    task automatic wait_cnt(input logic [7:0] val, input int limit);
        found = 0;
        for (int k = 0; k < limit; k++) begin
            if (cnt == val) begin
                found = 1;
                break;
            end
            step();
        end
    endtask

    // Step until a period_start sample, at most limit cycles
    task automatic wait_ps(input int limit);
        found = 0;
        for (int k = 0; k < limit; k++) begin
            step();
            if (period_start) begin
                found = 1;
                break;
            end
        end
    endtask

    // Run n cycles collecting high counts, period starts and a few cnt samples
    task automatic window(input int n);
        for (int k = 0; k < 4; k++) hi[k] = 0;
        ps_n     = 0;
        first_ps = -1;
        for (int j = 1; j <= n; j++) begin
            step();
            for (int k = 0; k < 4; k++) if (pwm_out[k]) hi[k]++;
            if (period_start) begin
                ps_n++;
                if (first_ps < 0) first_ps = j;
            end
            if (j == 254) c254 = cnt;
            if (j == 255) c255 = cnt;
            if (j == 256) c256 = cnt;
        end
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;

        // Reset held two cycles with random inputs
        rst       = 1'b1;
        en        = 1'($urandom);
        prescale  = 8'($urandom);
        mode_in   = 1'($urandom);
        duty_in   = $urandom;
        duty_load = 1'($urandom);
        step();
        step();
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_ps", 32'(period_start), 32'd0);

        // Release reset idle, load ch0 duty 64 edge mode
        en        = 1'b0;
        prescale  = 8'd0;
        mode_in   = 1'b0;
        duty_in   = 32'h0000_0040;
        duty_load = 1'b1;
        rst       = 1'b0;
        step();
        duty_load = 1'b0;
        step();
        chk("idle_cnt", 32'(cnt), 32'd0);

        // Enable: first tick takes cnt to 1, no period_start
        en = 1'b1;
        step();
        chk("en_first_cnt", 32'(cnt), 32'd1);
        chk("en_first_ps", 32'(period_start), 32'd0);
        chk("en_first_pwm", 32'(pwm_out), 32'd1);

        // Edge, prescale 0, duty 64: 64 of 256 high, period 256
        wait_ps(300);
        chk("edge_align", 32'(found), 32'd1);
        window(512);
        chk("edge_hi0", 32'(hi[0]), 32'd128);
        chk("edge_hi1", 32'(hi[1]), 32'd0);
        chk("edge_ps_n", 32'(ps_n), 32'd2);
        chk("edge_period", 32'(first_ps), 32'd256);

        // Prescale 3: one counter step per 4 clk, period 1024
        prescale = 8'd3;
        c0 = cnt;
        step(); step(); step(); step();
        chk("pre3_step", 32'(cnt), 32'(8'(c0 + 8'd1)));
        wait_ps(1100);
        chk("pre3_align", 32'(found), 32'd1);
        window(2048);
        chk("pre3_hi0", 32'(hi[0]), 32'd512);
        chk("pre3_ps_n", 32'(ps_n), 32'd2);
        chk("pre3_period", 32'(first_ps), 32'd1024);

        // Mid-period load at cnt=100: no change until wrap
        prescale = 8'd0;
        wait_cnt(8'd100, 2000);
        chk("mid_wait", 32'(found), 32'd1);
        duty_in   = {8'd128, 8'd255, 8'd0, 8'd200};
        duty_load = 1'b1;
        step();
        duty_load = 1'b0;
        run_hi0 = 0;
        found   = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (period_start) begin
                found = 1;
                break;
            end
            if (pwm_out[0]) run_hi0++;
        end
        chk("mid_reach_wrap", 32'(found), 32'd1);
        chk("mid_no_runt", 32'(run_hi0), 32'd0);
        window(256);
        chk("new_hi0_200", 32'(hi[0]), 32'd200);
        chk("new_hi1_0", 32'(hi[1]), 32'd0);
        chk("new_hi2_255", 32'(hi[2]), 32'd255);
        chk("new_hi3_128", 32'(hi[3]), 32'd128);
        chk("new_period", 32'(first_ps), 32'd256);

        // Load on the boundary cycle takes effect in that period
        wait_cnt(8'd255, 300);
        chk("bnd_wait", 32'(found), 32'd1);
        duty_in   = {8'd128, 8'd255, 8'd0, 8'd10};
        duty_load = 1'b1;
        step();
        duty_load = 1'b0;
        chk("bnd_ps", 32'(period_start), 32'd1);
        chk("bnd_cnt", 32'(cnt), 32'd0);
        window(256);
        chk("bnd_hi0", 32'(hi[0]), 32'd10);

        // Center mode from the next boundary, period 510
        wait_cnt(8'd255, 300);
        chk("ctr_wait", 32'(found), 32'd1);
        duty_in   = {8'd128, 8'd255, 8'd0, 8'd128};
        mode_in   = 1'b1;
        duty_load = 1'b1;
        step();
        duty_load = 1'b0;
        chk("ctr_ps", 32'(period_start), 32'd1);
        window(510);
        chk("ctr_hi0", 32'(hi[0]), 32'd255);
        chk("ctr_hi1", 32'(hi[1]), 32'd0);
        chk("ctr_hi2", 32'(hi[2]), 32'd509);
        chk("ctr_hi3", 32'(hi[3]), 32'd255);
        chk("ctr_ps_n", 32'(ps_n), 32'd1);
        chk("ctr_period", 32'(first_ps), 32'd510);
        chk("ctr_c254", 32'(c254), 32'd254);
        chk("ctr_c255", 32'(c255), 32'd255);
        chk("ctr_c256", 32'(c256), 32'd254);

        // Drop enable mid-period
        wait_cnt(8'd50, 600);
        chk("dis_wait", 32'(found), 32'd1);
        en = 1'b0;
        step();
        chk("dis_pwm", 32'(pwm_out), 32'd0);
        chk("dis_cnt", 32'(cnt), 32'd0);
        chk("dis_ps", 32'(period_start), 32'd0);
        step();
        chk("dis_hold_cnt", 32'(cnt), 32'd0);

        // Re-enable: first tick to 1, no period_start
        en = 1'b1;
        step();
        chk("reen_cnt", 32'(cnt), 32'd1);
        chk("reen_ps", 32'(period_start), 32'd0);
        chk("reen_pwm", 32'(pwm_out), 32'b1101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
